register_bank_pairs: RTL



---
 rtl/register_bank_pairs.sv | 95 +++++++++
 1 files changed

// File: rtl/register_bank_pairs.sv
// Byte/pair register bank with dual byte reads, pair read, byte/pair writes and pair inc/dec.
// Define REGBANK_WRITE_BYPASS_EN to forward same-cycle write data onto the read ports.
module register_bank_pairs #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned REG_ADDR_W  = 3,
    parameter int unsigned PAIR_ADDR_W = REG_ADDR_W - 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_W-1:0]     rdSelA,
    output logic [DATA_WIDTH-1:0]     rdDataA,
    input  logic [REG_ADDR_W-1:0]     rdSelB,
    output logic [DATA_WIDTH-1:0]     rdDataB,
    input  logic [PAIR_ADDR_W-1:0]    rdPairSel,
    output logic [2*DATA_WIDTH-1:0]   rdPair,
    input  logic                      wrEn,
    input  logic [REG_ADDR_W-1:0]     wrSel,
    input  logic [DATA_WIDTH-1:0]     wrData,
    input  logic                      wrPairEn,
    input  logic [PAIR_ADDR_W-1:0]    wrPairSel,
    input  logic [2*DATA_WIDTH-1:0]   wrPairData,
    input  logic                      incdecEn,
    input  logic [PAIR_ADDR_W-1:0]    incdecSel,
    input  logic                      incdecDir,
    output logic                      pairCarry
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
    localparam int unsigned PW       = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] regs     [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_nxt [NUM_REGS];
    logic [DATA_WIDTH-1:0] view     [NUM_REGS];

    logic [PW-1:0] id_val;
    logic [PW-1:0] id_res;
    logic          id_carry;

    // Full-width carry across both bytes; wrap flag taken from the pre-edge value.
    always_comb begin
        id_val   = {regs[{incdecSel, 1'b0}], regs[{incdecSel, 1'b1}]};
        id_res   = incdecDir ? (id_val - PW'(1)) : (id_val + PW'(1));
        id_carry = incdecDir ? (id_val == '0) : (id_val == '1);
    end

    // Later assignments win: pair write > inc/dec > byte write, resolved per byte.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_nxt[i] = regs[i];
            if (wrEn && (wrSel == i[REG_ADDR_W-1:0]))
                regs_nxt[i] = wrData;
            if (incdecEn && (incdecSel == i[REG_ADDR_W-1:1]))
                regs_nxt[i] = i[0] ? id_res[DATA_WIDTH-1:0] : id_res[PW-1:DATA_WIDTH];
            if (wrPairEn && (wrPairSel == i[REG_ADDR_W-1:1]))
                regs_nxt[i] = i[0] ? wrPairData[DATA_WIDTH-1:0] : wrPairData[PW-1:DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            pairCarry <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= regs_nxt[i];
            if (incdecEn)
                pairCarry <= id_carry;
        end
    end

`ifdef REGBANK_WRITE_BYPASS_EN
    // Bytes of an inc/dec'd pair show pre-edge data unless a pair write overrides them.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            view[i] = regs[i];
            if (wrEn && (wrSel == i[REG_ADDR_W-1:0]) &&
                !(incdecEn && (incdecSel == i[REG_ADDR_W-1:1])))
                view[i] = wrData;
            if (wrPairEn && (wrPairSel == i[REG_ADDR_W-1:1]))
                view[i] = i[0] ? wrPairData[DATA_WIDTH-1:0] : wrPairData[PW-1:DATA_WIDTH];
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++)
            view[i] = regs[i];
    end
`endif

    assign rdDataA = view[rdSelA];
    assign rdDataB = view[rdSelB];
    assign rdPair  = {view[{rdPairSel, 1'b0}], view[{rdPairSel, 1'b1}]};

endmodule
